// File: rtl/rpn.sv
// rpn: 8-bit RPN calculator top level; define RPN_DIV_EN to turn op 11 from swap into divide.
module rpn #(
  parameter int DEPTH = 8
) (
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  input  logic       CLOCK_50
);
  logic rst;
  logic [2:0] s1, s2, p, fall;
  logic [7:0] stk [DEPTH];
  logic [7:0] stk_n [DEPTH];
  logic [3:0] sp, sp_n;
  logic err, err_n, flag, flag_n;
  logic [7:0] t, s, res;
  logic [8:0] sum, dif;
  logic [15:0] prod;
  logic fl, bad;
  assign rst = ~KEY[1];
  // bit0 enter, bit1 operate, bit2 drop
  always_ff @(posedge CLOCK_50 or posedge rst)
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
      p <= '1;
    end else begin
      s1 <= {KEY[3], KEY[2], KEY[0]};
      s2 <= s1;
      p <= s2;
    end
  assign fall = p & ~s2;
  assign t = stk[0];
  assign s = stk[1];
  assign sum = {1'b0, s} + {1'b0, t};
  assign dif = {1'b0, s} - {1'b0, t};
  assign prod = s * t;
  always_comb begin
`ifdef RPN_DIV_EN
    bad = sp < 4'd2 || (SW[9:8] == 2'b11 && t == 8'd0);
    res = SW[9:8] == 2'b00 ? sum[7:0] : SW[9:8] == 2'b01 ? dif[7:0] :
          SW[9:8] == 2'b10 ? prod[7:0] : s / t;
    fl = SW[9:8] == 2'b00 ? sum[8] : SW[9:8] == 2'b01 ? dif[8] :
         SW[9:8] == 2'b10 ? |prod[15:8] : (s % t) != 8'd0;
`else
    bad = sp < 4'd2;
    res = SW[9:8] == 2'b00 ? sum[7:0] : SW[9:8] == 2'b01 ? dif[7:0] : prod[7:0];
    fl = SW[9:8] == 2'b00 ? sum[8] : SW[9:8] == 2'b01 ? dif[8] :
         SW[9:8] == 2'b10 ? |prod[15:8] : 1'b0;
`endif
  end
  // stk[0] is the top of stack; pushes shift down, pops shift up
  always_comb begin
    stk_n = stk;
    sp_n = sp;
    err_n = err;
    flag_n = flag;
    if (fall[0]) begin
      if (sp < 4'(DEPTH)) begin
        for (int i = 1; i < DEPTH; i++) stk_n[i] = stk[i-1];
        stk_n[0] = SW[7:0];
        sp_n = sp + 4'd1;
        err_n = 1'b0;
        flag_n = 1'b0;
      end else err_n = 1'b1;
    end else if (fall[1]) begin
      if (bad) err_n = 1'b1;
`ifndef RPN_DIV_EN
      else if (SW[9:8] == 2'b11) begin
        stk_n[0] = s;
        stk_n[1] = t;
        err_n = 1'b0;
        flag_n = 1'b0;
      end
`endif
      else begin
        stk_n[0] = res;
        for (int i = 1; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
        stk_n[DEPTH-1] = 8'd0;
        sp_n = sp - 4'd1;
        err_n = 1'b0;
        flag_n = fl;
      end
    end else if (fall[2]) begin
      if (sp == 4'd0) err_n = 1'b1;
      else begin
        for (int i = 0; i < DEPTH - 1; i++) stk_n[i] = stk[i+1];
        stk_n[DEPTH-1] = 8'd0;
        sp_n = sp - 4'd1;
        err_n = 1'b0;
        flag_n = 1'b0;
      end
    end
  end
  always_ff @(posedge CLOCK_50 or posedge rst)
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= 8'd0;
      sp <= 4'd0;
      err <= 1'b0;
      flag <= 1'b0;
    end else begin
      stk <= stk_n;
      sp <= sp_n;
      err <= err_n;
      flag <= flag_n;
    end
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  endfunction
  assign HEX0 = sp >= 4'd1 ? seg(t[3:0]) : 7'h7F;
  assign HEX1 = sp >= 4'd1 ? seg(t[7:4]) : 7'h7F;
  assign HEX2 = sp >= 4'd2 ? seg(s[3:0]) : 7'h7F;
  assign HEX3 = sp >= 4'd2 ? seg(s[7:4]) : 7'h7F;
  assign HEX4 = seg(sp);
  assign HEX5 = err ? 7'h06 : 7'h7F;
  assign LEDR = {err, flag, 4'd0, sp};
endmodule

// File: tb/tb_rpn.sv
// tb_rpn: directed self-checking bench for the rpn calculator.
module tb_rpn;
  logic clk = 1'b0;
  logic [3:0] key = 4'b1111;
  logic [9:0] sw = '0;
  logic [9:0] ledr;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
  int checks = 0;
  int errors = 0;
  rpn dut (
    .KEY(key), .SW(sw), .LEDR(ledr),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3), .HEX4(hex4), .HEX5(hex5),
    .CLOCK_50(clk)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask
  task automatic press(input logic [3:0] m, input int n);
    @(negedge clk);
    key = key & ~m;
    repeat (n) @(negedge clk);
    key = 4'b1111;
    repeat (5) @(negedge clk);
  endtask
  task automatic push(input logic [9:0] v);
    sw = v;
    press(4'b0001, 1);
  endtask
  task automatic reset_pulse();
    @(negedge clk);
    key[1] = 1'b0;
    #1;
    check("async_rst_ledr", ledr, 10'h000);
    @(negedge clk);
    key[1] = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    reset_pulse();
    check("rst_hex0", {3'd0, hex0}, 10'h07F);
    check("rst_hex3", {3'd0, hex3}, 10'h07F);
    check("rst_hex4", {3'd0, hex4}, 10'h040);
    check("rst_hex5", {3'd0, hex5}, 10'h07F);
    push(10'h0AE);
    check("p1_hex1", {3'd0, hex1}, 10'h008);
    check("p1_hex0", {3'd0, hex0}, 10'h006);
    check("p1_hex4", {3'd0, hex4}, 10'h079);
    check("p1_hex2", {3'd0, hex2}, 10'h07F);
    check("p1_hex3", {3'd0, hex3}, 10'h07F);
    check("p1_ledr", ledr, 10'h001);
    push(10'h083);
    check("p2_hex1", {3'd0, hex1}, 10'h000);
    check("p2_hex0", {3'd0, hex0}, 10'h030);
    check("p2_hex3", {3'd0, hex3}, 10'h008);
    check("p2_hex2", {3'd0, hex2}, 10'h006);
    check("p2_ledr", ledr, 10'h002);
    reset_pulse();
    check("mid_rst_hex0", {3'd0, hex0}, 10'h07F);
    check("mid_rst_hex2", {3'd0, hex2}, 10'h07F);
    for (int i = 1; i <= 4; i++) begin
      push(10'h083);
      check("cnt_ledr", ledr, 10'(i));
      check("cnt_hex0", {3'd0, hex0}, 10'h030);
      check("cnt_hex1", {3'd0, hex1}, 10'h000);
    end
    reset_pulse();
    push(10'h0EF);
    check("ef_hex1", {3'd0, hex1}, 10'h006);
    check("ef_hex0", {3'd0, hex0}, 10'h00E);
    check("ef_ledr", ledr, 10'h001);
    reset_pulse();
    push(10'h083);
    push(10'h083);
    sw = 10'h000;
    press(4'b0100, 1);
    check("add_ledr", ledr, 10'h101);
    check("add_hex0", {3'd0, hex0}, 10'h002);
    check("add_hex1", {3'd0, hex1}, 10'h040);
    check("add_hex2", {3'd0, hex2}, 10'h07F);
    press(4'b0100, 1);
    check("op_short_err", {9'd0, ledr[9]}, 10'h001);
    check("op_short_sp", {6'd0, ledr[3:0]}, 10'h001);
    check("op_short_hex0", {3'd0, hex0}, 10'h002);
    check("op_short_hex5", {3'd0, hex5}, 10'h006);
    reset_pulse();
    push(10'h005);
    push(10'h007);
    sw = 10'h100;
    press(4'b0100, 1);
    check("sub_ledr", ledr, 10'h101);
    check("sub_hex1", {3'd0, hex1}, 10'h00E);
    check("sub_hex0", {3'd0, hex0}, 10'h006);
    reset_pulse();
    push(10'h00C);
    push(10'h00B);
    sw = 10'h200;
    press(4'b0100, 1);
    check("mul_ledr", ledr, 10'h001);
    check("mul_hex1", {3'd0, hex1}, 10'h000);
    check("mul_hex0", {3'd0, hex0}, 10'h019);
    push(10'h010);
    push(10'h020);
    sw = 10'h200;
    press(4'b0100, 1);
    check("mul_ovf_ledr", ledr, 10'h102);
    check("mul_ovf_hex0", {3'd0, hex0}, 10'h040);
    press(4'b1000, 1);
    push(10'h012);
    sw = 10'h300;
    press(4'b0100, 1);
`ifdef RPN_DIV_EN
    check("div_ledr", ledr, 10'h101);
    check("div_hex0", {3'd0, hex0}, 10'h078);
    check("div_hex1", {3'd0, hex1}, 10'h040);
`else
    check("swap_ledr", ledr, 10'h002);
    check("swap_hex0", {3'd0, hex0}, 10'h019);
    check("swap_hex1", {3'd0, hex1}, 10'h000);
    check("swap_hex2", {3'd0, hex2}, 10'h024);
    check("swap_hex3", {3'd0, hex3}, 10'h079);
`endif
    reset_pulse();
    push(10'h055);
    press(4'b1000, 1);
    check("drop_ledr", ledr, 10'h000);
    check("drop_hex0", {3'd0, hex0}, 10'h07F);
    press(4'b1000, 1);
    check("drop_empty_ledr", ledr, 10'h200);
    check("drop_empty_hex5", {3'd0, hex5}, 10'h006);
    reset_pulse();
    for (int i = 1; i <= 8; i++) push(10'(i));
    check("full_ledr", ledr, 10'h008);
    push(10'h009);
    check("over_ledr", ledr, 10'h208);
    check("over_hex0", {3'd0, hex0}, 10'h000);
    check("over_hex1", {3'd0, hex1}, 10'h040);
    press(4'b1000, 1);
    check("drop_full_ledr", ledr, 10'h007);
    check("drop_full_hex0", {3'd0, hex0}, 10'h078);
    push(10'h009);
    check("repush_ledr", ledr, 10'h008);
    check("repush_hex0", {3'd0, hex0}, 10'h010);
    reset_pulse();
    push(10'h001);
    sw = 10'h002;
    press(4'b1101, 1);
    check("prio_ledr", ledr, 10'h002);
    check("prio_hex0", {3'd0, hex0}, 10'h024);
    sw = 10'h004;
    press(4'b1000, 1);
    sw = 10'h003;
    press(4'b0001, 6);
    check("hold_ledr", ledr, 10'h002);
    check("hold_hex0", {3'd0, hex0}, 10'h030);
    check("hold_hex2", {3'd0, hex2}, 10'h079);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
